// File: rtl/cnn_batch_sequencer.sv
// Batch sequencer: streams each image from pixel ROM into a CNN, collects the decision,
// compares it to the label ROM. Optional WAIT_RES timeout enabled by macro CNN_SEQ_TIMEOUT_EN.
module cnn_batch_sequencer #(
  parameter int IMG_PIXELS = 784,
  parameter int NUM_IMAGES = 1000,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [19:0] pix_addr,
  output logic        pix_en,
  input  logic [7:0]  pix_data,
  output logic [9:0]  lbl_addr,
  input  logic [3:0]  lbl_data,
  output logic        cnn_rst_n,
  output logic [7:0]  cnn_data,
  input  logic [3:0]  cnn_decision,
  input  logic        cnn_finish,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic [9:0]  result_idx,
  output logic [3:0]  result_dec,
  output logic        result_hit,
  output logic [9:0]  correct_cnt,
  output logic        timeout_flag
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CNN_RST  = 3'd1;
  localparam logic [2:0] STREAM   = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] RECORD   = 3'd4;
  localparam logic [2:0] FINISH   = 3'd5;

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic [2:0]  state;
  logic [9:0]  img_idx;
  logic [19:0] base;
  logic [19:0] kc;
  logic [15:0] rcnt;
  logic [31:0] wcnt;
  logic        rel;
  logic        pv;
  logic        fin_seen;
  logic [3:0]  dec_r;
  logic [3:0]  label_r;

  // STREAM lasts IMG_PIXELS+1 cycles: the extra cycle is when the last pixel returns.
  assign pix_en       = (state == STREAM) && (kc < 20'(IMG_PIXELS));
  assign pix_addr     = pix_en ? (base + kc) : '0;
  assign lbl_addr     = img_idx;
  assign cnn_rst_n    = rel;
  assign cnn_data     = pv ? pix_data : '0;
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH) && !abort;
  assign result_valid = (state == RECORD) && !abort;
  assign result_idx   = img_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      img_idx      <= '0;
      base         <= '0;
      kc           <= '0;
      rcnt         <= '0;
      wcnt         <= '0;
      rel          <= 1'b0;
      pv           <= 1'b0;
      fin_seen     <= 1'b0;
      dec_r        <= '0;
      label_r      <= '0;
      result_dec   <= '0;
      result_hit   <= 1'b0;
      correct_cnt  <= '0;
      timeout_flag <= 1'b0;
    end else begin
      pv <= pix_en && !abort;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        rel      <= 1'b0;
        fin_seen <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= CNN_RST;
              img_idx      <= '0;
              base         <= '0;
              rcnt         <= '0;
              rel          <= 1'b0;
              fin_seen     <= 1'b0;
              correct_cnt  <= '0;
              timeout_flag <= 1'b0;
            end
          end
          CNN_RST: begin
            rcnt <= rcnt + 16'd1;
            if (rcnt == 16'(RST_CYCLES - 1)) begin
              state <= STREAM;
              kc    <= '0;
            end
          end
          STREAM: begin
            kc <= kc + 20'd1;
            if (kc == 20'd0) rel <= 1'b1;
            if (kc == 20'd1) label_r <= lbl_data;
            // An early finish is held here so WAIT_RES can consume it immediately.
            if (cnn_finish && !fin_seen) begin
              fin_seen <= 1'b1;
              dec_r    <= cnn_decision;
            end
            if (kc == 20'(IMG_PIXELS)) begin
              state <= WAIT_RES;
              wcnt  <= '0;
            end
          end
          WAIT_RES: begin
            if (fin_seen) begin
              state      <= RECORD;
              result_dec <= dec_r;
              result_hit <= (dec_r == label_r);
            end else if (cnn_finish) begin
              state      <= RECORD;
              result_dec <= cnn_decision;
              result_hit <= (cnn_decision == label_r);
            end else if (TO_EN && wcnt == 32'(TIMEOUT - 1)) begin
              state        <= RECORD;
              result_dec   <= 4'hF;
              result_hit   <= 1'b0;
              timeout_flag <= 1'b1;
            end else begin
              wcnt <= wcnt + 32'd1;
            end
          end
          RECORD: begin
            if (result_hit && correct_cnt != 10'h3FF) correct_cnt <= correct_cnt + 10'd1;
            if (img_idx == 10'(NUM_IMAGES - 1)) begin
              state <= FINISH;
            end else begin
              state    <= CNN_RST;
              img_idx  <= img_idx + 10'd1;
              base     <= base + 20'(IMG_PIXELS);
              rcnt     <= '0;
              rel      <= 1'b0;
              fin_seen <= 1'b0;
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
